execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage_pkg.sv | 61 ++++++
 rtl/execute_stage_alu_core.sv | 43 ++++
 rtl/execute_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/execute_stage_pkg.sv
// ---------------------------------------------------------------------------
// execute_stage_pkg
// Shared definitions for the execute stage and the decode-side control unit:
//   - ALU op-code encodings (alu_op_e)
//   - control bundle, E-stage and M-stage register layouts
//   - the all-zero bubble value for each bundle
//   - destination-register select helper
// ---------------------------------------------------------------------------
package execute_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0010,
        ALU_AND = 4'b0100,
        ALU_OR  = 4'b0101,
        ALU_XOR = 4'b0110,
        ALU_NOR = 4'b0111,
        ALU_SLT = 4'b1011,
        ALU_SLL = 4'b1110,
        ALU_SRL = 4'b1101,
        ALU_SRA = 4'b1100
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic memto_reg;
        logic mem_write;
        logic reg_dst;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [3:0]  alu_control;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] write_data;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } e_reg_t;

    typedef struct packed {
        logic        reg_write;
        logic        memto_reg;
        logic        mem_write;
        logic        zero;
        logic [31:0] alu_out;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
    } m_reg_t;

    localparam ctrl_t  CTRL_BUBBLE = '0;
    localparam e_reg_t E_BUBBLE    = '0;
    localparam m_reg_t M_BUBBLE    = '0;

    // R-type instructions write rd, I-type write rt.
    function automatic logic [4:0] select_dest(input logic reg_dst,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd);
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/execute_stage_alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational 32-bit ALU.
// Ports:
//   a, b   (in, 32) operands; shifts use b[4:0] only
//   code   (in, 4)  op code from execute_stage_pkg::alu_op_e
//   result (out,32) ALU result; unknown codes yield 0
//   zero   (out,1)  result == 0
// Add wraps modulo 2^32; no overflow indication exists.
// ---------------------------------------------------------------------------
module alu_core
    import execute_stage_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  code,
    output logic [31:0] result,
    output logic        zero
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (code)
            ALU_ADD: result = a + b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SRA: result = 32'($signed(a) >>> shamt);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// E-stage pipeline register, ALU, and M-stage pipeline register of a
// 5-stage MIPS-style pipeline. D inputs reach M outputs after 2 edges.
// Ports:
//   clock, reset_n            clock / async active-low reset
//   stallE                    hold E register, bubble into M register
//   flushE                    bubble into E register (wins over stallE)
//   RegWriteD..RegDstD        decode control bundle
//   ALUControlD               ALU op code
//   regA, regB                ALU operands
//   WriteDataD                store data (rt value)
//   rtD, rdD                  destination candidates
//   RegWriteE, WriteRegE      E-stage hazard visibility
//   RegWriteM, MemtoRegM, MemWriteM, ZeroM, ALUOutM, WriteDataM, WriteRegM
//                             M-stage register outputs
// ---------------------------------------------------------------------------
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stallE,
    input  logic        flushE,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        MemWriteD,
    input  logic        RegDstD,
    input  logic [3:0]  ALUControlD,
    input  logic [31:0] regA,
    input  logic [31:0] regB,
    input  logic [31:0] WriteDataD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rdD,
    output logic        RegWriteE,
    output logic [4:0]  WriteRegE,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic        MemWriteM,
    output logic        ZeroM,
    output logic [31:0] ALUOutM,
    output logic [31:0] WriteDataM,
    output logic [4:0]  WriteRegM
);

    e_reg_t      e_d;
    e_reg_t      e_q;
    m_reg_t      m_d;
    m_reg_t      m_q;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [4:0]  write_reg_e;

    always_comb begin
        e_d                     = E_BUBBLE;
        e_d.ctrl.reg_write      = RegWriteD;
        e_d.ctrl.memto_reg      = MemtoRegD;
        e_d.ctrl.mem_write      = MemWriteD;
        e_d.ctrl.reg_dst        = RegDstD;
        e_d.alu_control         = ALUControlD;
        e_d.src_a               = regA;
        e_d.src_b               = regB;
        e_d.write_data          = WriteDataD;
        e_d.rt                  = rtD;
        e_d.rd                  = rdD;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= E_BUBBLE;
        end else if (flushE) begin
            e_q <= E_BUBBLE;
        end else if (!stallE) begin
            e_q <= e_d;
        end
    end

    alu_core u_alu (
        .a      (e_q.src_a),
        .b      (e_q.src_b),
        .code   (e_q.alu_control),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign write_reg_e = select_dest(e_q.ctrl.reg_dst, e_q.rt, e_q.rd);

    always_comb begin
        m_d            = M_BUBBLE;
        m_d.reg_write  = e_q.ctrl.reg_write;
        m_d.memto_reg  = e_q.ctrl.memto_reg;
        m_d.mem_write  = e_q.ctrl.mem_write;
        m_d.zero       = alu_zero;
        m_d.alu_out    = alu_result;
        m_d.write_data = e_q.write_data;
        m_d.write_reg  = write_reg_e;
    end

    // A flush keeps the M side advancing: the instruction already in E is
    // older than the one being squashed and must still complete.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q <= M_BUBBLE;
        end else if (stallE && !flushE) begin
            m_q <= M_BUBBLE;
        end else begin
            m_q <= m_d;
        end
    end

    assign RegWriteE  = e_q.ctrl.reg_write;
    assign WriteRegE  = write_reg_e;
    assign RegWriteM  = m_q.reg_write;
    assign MemtoRegM  = m_q.memto_reg;
    assign MemWriteM  = m_q.mem_write;
    assign ZeroM      = m_q.zero;
    assign ALUOutM    = m_q.alu_out;
    assign WriteDataM = m_q.write_data;
    assign WriteRegM  = m_q.write_reg;

endmodule
